// File: rtl/apb_multi_fifo_if.sv
// rtl/apb_multi_fifo_if.sv - APB4 bus bundle for apb_multi_fifo
interface apb_multi_fifo_if;
  logic [31:0] PADDR;
  logic [2:0]  PPROT;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  modport master (
    output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_multi_fifo.sv
// rtl/apb_multi_fifo.sv - APB4 slave with NUM_CH runtime-sized FIFOs
// Optional LEVEL[ch] count readback enabled by APB_MULTI_FIFO_LEVEL_EN.
module apb_multi_fifo #(
  parameter int WIDTH     = 8,
  parameter int NUM_CH    = 4,
  parameter int MAX_DEPTH = 256
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_multi_fifo_if.slave   apb,
  output logic [NUM_CH-1:0] full,
  output logic [NUM_CH-1:0] empty
);
  localparam int         AW        = $clog2(MAX_DEPTH);
  localparam int         CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [3:0] MAX_CODE  = 4'(AW - 2);
  localparam logic [5:0] NUM_SLOTS = 6'(NUM_CH);

  logic [3:0]       cfg   [NUM_CH];
  logic [AW-1:0]    rptr  [NUM_CH];
  logic [AW-1:0]    wptr  [NUM_CH];
  logic [AW:0]      count [NUM_CH];
  logic [AW:0]      depth [NUM_CH];
  logic [WIDTH-1:0] mem   [NUM_CH][MAX_DEPTH];

  logic          access;
  logic          slot_ok;
  logic          is_cfg;
  logic          is_status;
  logic          is_data;
  logic [CW-1:0] ch;
  logic          cfg_legal;
  logic [AW-1:0] depth_mask;
  logic [31:0]   status;
  logic [31:0]   rdata;
  logic          err;
  logic          do_push;
  logic          do_pop;
  logic          do_cfg;
  logic          unused;

  assign access    = apb.PSEL & apb.PENABLE;
  assign ch        = apb.PADDR[2 +: CW];
  assign slot_ok   = (apb.PADDR[1:0] == 2'b00) && (apb.PADDR[7:2] < NUM_SLOTS);
  assign is_cfg    = (apb.PADDR[31:8] == 24'h00_0000) && slot_ok;
  assign is_status = (apb.PADDR == 32'h0000_0100);
  assign is_data   = (apb.PADDR[31:8] == 24'h80_0000) && slot_ok;
  assign cfg_legal = (apb.PWDATA[3:0] != 4'd0) && (apb.PWDATA[3:0] <= MAX_CODE);
  assign unused    = ^{apb.PPROT, apb.PSTRB[3:1], apb.PWDATA};

`ifdef APB_MULTI_FIFO_LEVEL_EN
  logic is_level;
  assign is_level = (apb.PADDR[31:8] == 24'h00_0002) && slot_ok;
`endif

  // Code c selects depth 8 << (c-1), i.e. 1 << (c+2).
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      depth[c] = (AW+1)'(1) << (cfg[c] + 4'd2);
    end
  end

  // At depth == MAX_DEPTH the low bits are zero, so the subtraction yields all ones.
  assign depth_mask = depth[ch][AW-1:0] - 1'b1;

  always_comb begin
    status = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      status[2*c]   = empty[c];
      status[2*c+1] = full[c];
    end
  end

  always_comb begin
    rdata   = '0;
    err     = 1'b0;
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_cfg  = 1'b0;
    if (access) begin
      if (is_cfg) begin
        if (apb.PWRITE) begin
          if (apb.PSTRB[0]) begin
            if (cfg_legal) do_cfg = 1'b1;
            else           err    = 1'b1;
          end
        end else begin
          rdata = {28'd0, cfg[ch]};
        end
      end else if (is_status) begin
        if (apb.PWRITE) err   = 1'b1;
        else            rdata = status;
      end else if (is_data) begin
        if (apb.PWRITE) begin
          if (count[ch] == depth[ch]) err     = 1'b1;
          else                        do_push = 1'b1;
        end else begin
          if (count[ch] == '0) begin
            err = 1'b1;
          end else begin
            rdata  = 32'(mem[ch][rptr[ch]]);
            do_pop = 1'b1;
          end
        end
      end
`ifdef APB_MULTI_FIFO_LEVEL_EN
      else if (is_level) begin
        if (apb.PWRITE) err   = 1'b1;
        else            rdata = 32'(count[ch]);
      end
`endif
      else begin
        err = 1'b1;
      end
    end
  end

  assign apb.PREADY  = 1'b1;
  assign apb.PRDATA  = rdata;
  assign apb.PSLVERR = err;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cfg[c]   <= 4'd1;
        rptr[c]  <= '0;
        wptr[c]  <= '0;
        count[c] <= '0;
      end
      full  <= '0;
      empty <= '1;
    end else begin
      if (do_cfg) begin
        cfg[ch]   <= apb.PWDATA[3:0];
        rptr[ch]  <= '0;
        wptr[ch]  <= '0;
        count[ch] <= '0;
        full[ch]  <= 1'b0;
        empty[ch] <= 1'b1;
      end
      if (do_push) begin
        wptr[ch]  <= (wptr[ch] + 1'b1) & depth_mask;
        count[ch] <= count[ch] + 1'b1;
        full[ch]  <= ((count[ch] + 1'b1) == depth[ch]);
        empty[ch] <= 1'b0;
      end
      if (do_pop) begin
        rptr[ch]  <= (rptr[ch] + 1'b1) & depth_mask;
        count[ch] <= count[ch] - 1'b1;
        full[ch]  <= 1'b0;
        empty[ch] <= (count[ch] == (AW+1)'(1));
      end
    end
  end

  // Storage has no reset; gating on PRESETn keeps an aborted push out of it.
  always_ff @(posedge PCLK) begin
    if (do_push && PRESETn) begin
      mem[ch][wptr[ch]] <= apb.PWDATA[WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_apb_multi_fifo.sv
// tb/tb_apb_multi_fifo.sv - scoreboard bench for apb_multi_fifo
module tb_apb_multi_fifo;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] full;
  logic [3:0] empty;

  apb_multi_fifo_if bus ();

  apb_multi_fifo #(.WIDTH(8), .NUM_CH(4), .MAX_DEPTH(256)) dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .apb     (bus),
    .full    (full),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [32:0] exp_q[$];
  string       name_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
  endtask

  task automatic xfer(input string name, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [31:0] exp_rdata, input logic exp_err);
    @(posedge clk); #1;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = wdata;
    bus.PSTRB   = strb;
    exp_q.push_back({exp_err, exp_rdata});
    name_q.push_back(name);
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
  endtask

  task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data, input logic exp_err);
    xfer(name, 1'b1, addr, data, 4'hF, 32'd0, exp_err);
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] expv, input logic exp_err);
    xfer(name, 1'b0, addr, 32'd0, 4'h0, expv, exp_err);
  endtask

  // Monitor: every access phase is matched against the oldest expectation.
  initial begin : monitor
    logic [32:0] e;
    string       nm;
    forever begin
      @(negedge clk);
      if (bus.PSEL && bus.PENABLE) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_access: got addr 0x%08h expected no transfer", bus.PADDR);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check({nm, " prdata"}, bus.PRDATA, e[31:0]);
          check({nm, " pslverr"}, {31'd0, bus.PSLVERR}, {31'd0, e[32]});
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  logic [7:0] b1 [8];

  initial begin
    b1 = '{8'hA5, 8'h3C, 8'h00, 8'hFF, 8'h12, 8'h81, 8'h7E, 8'hC9};
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0; bus.PSTRB = '0; bus.PPROT = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset empty", {28'd0, empty}, 32'h0000_000F);
    check("reset full", {28'd0, full}, 32'h0);
    check("reset prdata", bus.PRDATA, 32'h0);
    check("reset pslverr", {31'd0, bus.PSLVERR}, 32'h0);
    check("reset pready", {31'd0, bus.PREADY}, 32'h1);
    rst_n = 1'b1;

    for (int c = 0; c < 4; c++) rd($sformatf("cfg%0d reset", c), 32'(4*c), 32'h1, 1'b0);
    rd("status reset", 32'h100, 32'h55, 1'b0);

    // Channel 1 at depth 8: fill, overflow, drain, underflow.
    wr("cfg1 depth8", 32'h4, 32'h1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      wr($sformatf("push1_%0d", i), 32'h8000_0004, {24'd0, b1[i]}, 1'b0);
      if (i == 6) check("full1 after 7", {31'd0, full[1]}, 32'h0);
    end
    check("full1 after 8", {31'd0, full[1]}, 32'h1);
    check("empty others", {28'd0, empty}, 32'h0000_000D);
    wr("push1 overflow", 32'h8000_0004, 32'hEE, 1'b1);
    rd("status ch1 full", 32'h100, 32'h59, 1'b0);
    for (int i = 0; i < 8; i++) rd($sformatf("pop1_%0d", i), 32'h8000_0004, {24'd0, b1[i]}, 1'b0);
    rd("pop1 underflow", 32'h8000_0004, 32'h0, 1'b1);
    check("empty1 after drain", {31'd0, empty[1]}, 32'h1);
    rd("status drained", 32'h100, 32'h55, 1'b0);

    // Illegal depth codes leave CFG[0] alone; code 2 gives depth 16.
    wr("cfg0 code0", 32'h0, 32'h0, 1'b1);
    rd("cfg0 after code0", 32'h0, 32'h1, 1'b0);
    wr("cfg0 code7", 32'h0, 32'h7, 1'b1);
    rd("cfg0 after code7", 32'h0, 32'h1, 1'b0);
    wr("cfg0 code2", 32'h0, 32'h2, 1'b0);
    rd("cfg0 after code2", 32'h0, 32'h2, 1'b0);
    for (int i = 0; i < 16; i++) begin
      wr($sformatf("push0_%0d", i), 32'h8000_0000, 32'(i*16 + 3), 1'b0);
      if (i == 14) check("full0 after 15", {31'd0, full[0]}, 32'h0);
    end
    check("full0 after 16", {31'd0, full[0]}, 32'h1);
    wr("push0 overflow", 32'h8000_0000, 32'h55, 1'b1);
    for (int i = 0; i < 16; i++) rd($sformatf("pop0_%0d", i), 32'h8000_0000, 32'(i*16 + 3), 1'b0);
    for (int i = 0; i < 3; i++) wr($sformatf("push0w_%0d", i), 32'h8000_0000, 32'(8'hD0 + i), 1'b0);
    for (int i = 0; i < 3; i++) rd($sformatf("pop0w_%0d", i), 32'h8000_0000, 32'(8'hD0 + i), 1'b0);

    // Unmapped and read-only accesses.
    rd("rd 0xFFFF", 32'h0000_FFFF, 32'h0, 1'b1);
    wr("wr 0xFFFF", 32'h0000_FFFF, 32'h1, 1'b1);
    rd("rd 0xFFFFFFFF", 32'hFFFF_FFFF, 32'h0, 1'b1);
    wr("wr 0xFFFFFFFF", 32'hFFFF_FFFF, 32'h1, 1'b1);
    rd("rd cfg4", 32'h0000_0010, 32'h0, 1'b1);
    rd("rd data4", 32'h8000_0010, 32'h0, 1'b1);
    wr("wr status", 32'h100, 32'hFF, 1'b1);
    rd("status after bad", 32'h100, 32'h55, 1'b0);
    xfer("cfg3 no strb0", 1'b1, 32'hC, 32'h3, 4'hE, 32'h0, 1'b0);
    rd("cfg3 unchanged", 32'hC, 32'h1, 1'b0);

    // Flush by reconfiguring channel 2.
    for (int i = 0; i < 3; i++) wr($sformatf("push2_%0d", i), 32'h8000_0008, 32'(8'h40 + i), 1'b0);
    check("empty2 before flush", {31'd0, empty[2]}, 32'h0);
`ifdef APB_MULTI_FIFO_LEVEL_EN
    rd("level2 before", 32'h208, 32'h3, 1'b0);
    wr("level2 write", 32'h208, 32'h0, 1'b1);
`else
    rd("level2 unmapped", 32'h208, 32'h0, 1'b1);
`endif
    wr("cfg2 flush", 32'h8, 32'h1, 1'b0);
    check("empty2 after flush", {31'd0, empty[2]}, 32'h1);
    rd("pop2 after flush", 32'h8000_0008, 32'h0, 1'b1);
`ifdef APB_MULTI_FIFO_LEVEL_EN
    rd("level2 after", 32'h208, 32'h0, 1'b0);
`endif

    // Asynchronous reset returns all state at once.
    wr("cfg3 code3", 32'hC, 32'h3, 1'b0);
    wr("push3_0", 32'h8000_000C, 32'h11, 1'b0);
    check("empty3 before reset", {31'd0, empty[3]}, 32'h0);
    #3 rst_n = 1'b0;
    #1;
    check("async reset empty", {28'd0, empty}, 32'h0000_000F);
    check("async reset full", {28'd0, full}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    rd("cfg3 after reset", 32'hC, 32'h1, 1'b0);
    rd("pop3 after reset", 32'h8000_000C, 32'h0, 1'b1);

    repeat (3) @(posedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
